// File: rtl/bus_pkg.sv
// Shared bus constants and types.
// Holds the default master count, the watchdog length, bus widths and the
// arbiter FSM state type, plus a small round-robin pointer helper.
package bus_pkg;

    localparam int unsigned NUM_MASTERS = 2;
    localparam int unsigned BUS_TIMEOUT = 16;
    localparam int unsigned ADDR_WIDTH  = 16;
    localparam int unsigned DATA_WIDTH  = 16;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY,
        ARB_RESP
    } arb_state_e;

    // Index following idx in a ring of n entries.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
// Returns the first set request at or after ptr_i, wrapping to index 0.
// Ports:
//   req_i  - request vector, one bit per requester
//   ptr_i  - index with highest priority this round
//   idx_o  - granted index (0 when nothing requests)
//   any_o  - at least one request is set
module rr_pick
    import bus_pkg::*;
#(
    parameter int unsigned NUM_REQ = NUM_MASTERS,
    localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] wrap_idx;
    logic             hi_found;

    // Scan downwards so the lowest qualifying index is the last one written.
    // hi_* covers indices >= ptr_i; wrap_idx is the fallback after wrapping.
    always_comb begin
        hi_idx   = '0;
        wrap_idx = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                wrap_idx = IDX_W'(i);
                if (i >= int'(ptr_i)) begin
                    hi_idx   = IDX_W'(i);
                    hi_found = 1'b1;
                end
            end
        end
        any_o = |req_i;
        idx_o = hi_found ? hi_idx : wrap_idx;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter in front of the address decoder.
// Grants one requesting master, registers its request onto the shared bus,
// holds it until ready_i (or a watchdog timeout) and returns a one-cycle
// registered response to that master.
// Ports:
//   clk_i, rst_i              - clock, synchronous active-high reset
//   m_valid_i/addr/wdata/we   - per-master requests
//   m_ready_o, m_err_o        - per-master completion pulse and error
//   m_rdata_o                 - shared response data, valid with m_ready_o
//   valid_o/addr_o/wdata_o/we_o - registered bus request to the decoder
//   ready_i, rdata_i, err_i   - decoder response
//   grant_o                   - current or last granted master
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS    = bus_pkg::NUM_MASTERS,
    parameter int unsigned TIMEOUT_CYCLES = bus_pkg::BUS_TIMEOUT,
    localparam int unsigned IDX_W         = $clog2(NUM_MASTERS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NUM_MASTERS-1:0] m_valid_i,
    input  logic [ADDR_WIDTH-1:0] m_addr_i  [NUM_MASTERS],
    input  logic [DATA_WIDTH-1:0] m_wdata_i [NUM_MASTERS],
    input  logic [NUM_MASTERS-1:0] m_we_i,
    output logic [NUM_MASTERS-1:0] m_ready_o,
    output logic [DATA_WIDTH-1:0] m_rdata_o,
    output logic [NUM_MASTERS-1:0] m_err_o,
    output logic                  valid_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic                  we_o,
    input  logic                  ready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  err_i,
    output logic [IDX_W-1:0]      grant_o
);

    localparam int unsigned    CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e              state_q;
    logic [IDX_W-1:0]        rr_ptr_q;
    logic [IDX_W-1:0]        grant_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    valid_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic                    we_q;
    logic [NUM_MASTERS-1:0]  m_ready_q;
    logic [NUM_MASTERS-1:0]  m_err_q;
    logic [DATA_WIDTH-1:0]   m_rdata_q;

    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_any;
    logic [NUM_MASTERS-1:0]  grant_onehot;

    rr_pick #(
        .NUM_REQ (NUM_MASTERS)
    ) u_rr_pick (
        .req_i (m_valid_i),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        grant_onehot = NUM_MASTERS'(1) << grant_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ARB_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            m_ready_q <= '0;
            m_err_q   <= '0;
            m_rdata_q <= '0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (pick_any) begin
                        grant_q <= pick_idx;
                        addr_q  <= m_addr_i[pick_idx];
                        wdata_q <= m_wdata_i[pick_idx];
                        we_q    <= m_we_i[pick_idx];
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    // ready_i takes precedence over an expiring watchdog.
                    if (ready_i) begin
                        m_rdata_q <= rdata_i;
                        m_err_q   <= err_i ? grant_onehot : '0;
                        m_ready_q <= grant_onehot;
                        valid_q   <= 1'b0;
                        state_q   <= ARB_RESP;
                    end else if (cnt_q == CNT_LAST) begin
                        m_rdata_q <= '0;
                        m_err_q   <= grant_onehot;
                        m_ready_q <= grant_onehot;
                        valid_q   <= 1'b0;
                        state_q   <= ARB_RESP;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ARB_RESP: begin
                    m_ready_q <= '0;
                    m_err_q   <= '0;
                    rr_ptr_q  <= IDX_W'(rr_next(32'(grant_q), NUM_MASTERS));
                    state_q   <= ARB_IDLE;
                end
                default: begin
                    state_q <= ARB_IDLE;
                end
            endcase
        end
    end

    assign m_ready_o = m_ready_q;
    assign m_err_o   = m_err_q;
    assign m_rdata_o = m_rdata_q;
    assign valid_o   = valid_q;
    assign addr_o    = addr_q;
    assign wdata_o   = wdata_q;
    assign we_o      = we_q;
    assign grant_o   = grant_q;

endmodule
